// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with range 0..MAX: synchronous clear and load, and a
// choice of wrapping or saturating at either end of the range.
module updown_mod_counter #(
    parameter int unsigned    W    = 8,
    parameter logic [W-1:0]   INIT = 8'hFF,
    parameter logic [W-1:0]   MAX  = 8'hFF,
    parameter bit             SAT  = 1'b0
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    input  logic         en,
    input  logic         dir,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         wrap,
    output logic         ovf
);

    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ZERO = '0;

    logic [W-1:0] q_q, q_d;
    logic         wrap_q, wrap_d;
    logic         ovf_q, ovf_d;
    logic         at_max, at_zero;

    assign at_max  = (q_q == MAX);
    assign at_zero = (q_q == ZERO);

    // Priority is clr > ld > en. A boundary hit either folds or pins q,
    // and both cases raise the wrap pulse and the sticky ovf flag.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (clr) begin
            q_d   = INIT;
            ovf_d = 1'b0;
        end else if (ld) begin
            q_d = (d > MAX) ? MAX : d;
        end else if (en) begin
            if (dir) begin
                if (at_max) begin
                    q_d    = SAT ? MAX : ZERO;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    q_d = q_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    q_d    = SAT ? ZERO : MAX;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    q_d = q_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q_q    <= INIT;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    // tc looks at the live dir so a direction change is seen without a clock.
    assign tc   = dir ? at_max : at_zero;
    assign q    = q_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three instances (default wrap 0..FF, saturate
// 0..9, wrap 0..9) share stimulus; each expectation names the instance it checks.
module tb_updown_mod_counter;

    logic       clk;
    logic       rst_b;
    logic       clr, ld, en, dir;
    logic [7:0] d;

    logic [7:0] q0, q1, q2;
    logic       tc0, tc1, tc2, wr0, wr1, wr2, ov0, ov1, ov2;

    updown_mod_counter #(.W(8), .INIT(8'hFF), .MAX(8'hFF), .SAT(1'b0)) dut_def (
        .clk(clk), .rst_b(rst_b), .clr(clr), .ld(ld), .d(d), .en(en), .dir(dir),
        .q(q0), .tc(tc0), .wrap(wr0), .ovf(ov0));

    updown_mod_counter #(.W(8), .INIT(8'h00), .MAX(8'h09), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst_b(rst_b), .clr(clr), .ld(ld), .d(d), .en(en), .dir(dir),
        .q(q1), .tc(tc1), .wrap(wr1), .ovf(ov1));

    updown_mod_counter #(.W(8), .INIT(8'h00), .MAX(8'h09), .SAT(1'b0)) dut_mod (
        .clk(clk), .rst_b(rst_b), .clr(clr), .ld(ld), .d(d), .en(en), .dir(dir),
        .q(q2), .tc(tc2), .wrap(wr2), .ovf(ov2));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Record layout: {sel[1:0], q[7:0], tc, wrap, ovf}
    logic [12:0] exp_q[$];
    string       name_q[$];
    event        sample_ev;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic expect_out(input logic [1:0] s, input logic [7:0] eq,
                              input logic et, input logic ew, input logic eo,
                              input string nm);
        exp_q.push_back({s, eq, et, ew, eo});
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        logic [12:0] rec;
        string       nm;
        logic [10:0] act;
        forever begin
            @(negedge clk or sample_ev);
            while (exp_q.size() > 0) begin
                rec = exp_q.pop_front();
                nm  = name_q.pop_front();
                case (rec[12:11])
                    2'd0:    act = {q0, tc0, wr0, ov0};
                    2'd1:    act = {q1, tc1, wr1, ov1};
                    default: act = {q2, tc2, wr2, ov2};
                endcase
                n_cmp++;
                if (act !== rec[10:0]) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got q=%h tc=%b wrap=%b ovf=%b, want q=%h tc=%b wrap=%b ovf=%b",
                             nm, $time, act[10:3], act[2], act[1], act[0],
                             rec[10:3], rec[2], rec[1], rec[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic c, input logic l, input logic e,
                         input logic dr, input logic [7:0] dv);
        @(negedge clk);
        #1;
        clr = c; ld = l; en = e; dir = dr; d = dv;
    endtask

    // Drive one edge's inputs and queue the expected post-edge outputs.
    task automatic cycle(input logic c, input logic l, input logic e,
                         input logic dr, input logic [7:0] dv,
                         input logic [1:0] s, input logic [7:0] eq,
                         input logic et, input logic ew, input logic eo,
                         input string nm);
        drive(c, l, e, dr, dv);
        @(posedge clk);
        #1;
        expect_out(s, eq, et, ew, eo, nm);
    endtask

    // Short reset pulse after an edge; outputs checked while rst_b is low.
    task automatic async_pulse(input logic [1:0] s, input logic [7:0] eq,
                               input logic et, input string nm);
        @(posedge clk);
        #2 rst_b = 1'b0;
        #1;
        expect_out(s, eq, et, 1'b0, 1'b0, nm);
        -> sample_ev;
        #1 rst_b = 1'b1;
    endtask

    // Full reset of all instances, then release with idle inputs.
    task automatic hard_reset;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        rst_b = 1'b0;
        @(negedge clk);
        #1 rst_b = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        rst_b = 1'b0;
        clr = 1'b0; ld = 1'b0; en = 1'b0; dir = 1'b1; d = 8'h00;
        #1;
        expect_out(2'd0, 8'hFF, 1'b1, 1'b0, 1'b0, "rst_def");
        expect_out(2'd1, 8'h00, 1'b0, 1'b0, 1'b0, "rst_sat");
        expect_out(2'd2, 8'h00, 1'b0, 1'b0, 1'b0, "rst_mod");
        @(negedge clk);
        #1 rst_b = 1'b1;

        // Default instance: wrap mode, range 0..FF
        async_pulse(2'd0, 8'hFF, 1'b1, "async_pulse");
        cycle(0, 0, 1, 1, 8'h00, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, "up_wrap");
        cycle(0, 1, 0, 0, 8'h02, 2'd0, 8'h02, 1'b0, 1'b0, 1'b1, "ld_02");
        cycle(0, 0, 1, 0, 8'h00, 2'd0, 8'h01, 1'b0, 1'b0, 1'b1, "down_01");
        cycle(0, 0, 1, 0, 8'h00, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, "down_00_tc");
        cycle(0, 0, 1, 0, 8'h00, 2'd0, 8'hFF, 1'b0, 1'b1, 1'b1, "down_wrap");
        cycle(0, 0, 1, 0, 8'h00, 2'd0, 8'hFE, 1'b0, 1'b0, 1'b1, "down_fe");
        cycle(1, 1, 1, 1, 8'h3C, 2'd0, 8'hFF, 1'b1, 1'b0, 1'b0, "clr_prio");
        cycle(0, 1, 1, 1, 8'h3C, 2'd0, 8'h3C, 1'b0, 1'b0, 1'b0, "ld_prio");
        cycle(0, 0, 0, 1, 8'h00, 2'd0, 8'h3C, 1'b0, 1'b0, 1'b0, "hold");
        cycle(0, 1, 0, 1, 8'hFE, 2'd0, 8'hFE, 1'b0, 1'b0, 1'b0, "ld_fe");
        cycle(0, 0, 1, 1, 8'h00, 2'd0, 8'hFF, 1'b1, 1'b0, 1'b0, "up_ff_tc");
        cycle(0, 0, 1, 1, 8'h00, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, "up_wrap2");
        cycle(0, 0, 1, 0, 8'h00, 2'd0, 8'hFF, 1'b0, 1'b1, 1'b1, "b2b_down");
        cycle(0, 0, 1, 1, 8'h00, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, "b2b_up");
        cycle(0, 0, 0, 1, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, "wrap_drop");
        cycle(0, 0, 0, 0, 8'h00, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, "tc_dir_idle");
        cycle(0, 1, 0, 1, 8'h04, 2'd0, 8'h04, 1'b0, 1'b0, 1'b1, "ld_04");
        cycle(0, 0, 1, 1, 8'h00, 2'd0, 8'h05, 1'b0, 1'b0, 1'b1, "up_05");

        // Reset mid-count with en=1 pending, held across three edges
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        expect_out(2'd0, 8'hFF, 1'b1, 1'b0, 1'b0, "rst_mid");
        -> sample_ev;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 expect_out(2'd0, 8'hFF, 1'b1, 1'b0, 1'b0, "rst_hold");
        end
        @(negedge clk);
        #1 begin en = 1'b0; rst_b = 1'b1; end

        // Saturating instance, range 0..9
        hard_reset();
        for (int i = 1; i <= 12; i++)
            cycle(0, 0, 1, 1, 8'h00, 2'd1, (i < 9) ? 8'(i) : 8'h09,
                  (i >= 9), (i >= 10), (i >= 10), "sat_up");
        cycle(0, 1, 0, 1, 8'h0F, 2'd1, 8'h09, 1'b1, 1'b0, 1'b1, "sat_ld_clamp");
        cycle(0, 1, 0, 0, 8'h01, 2'd1, 8'h01, 1'b0, 1'b0, 1'b1, "sat_ld_01");
        cycle(0, 0, 1, 0, 8'h00, 2'd1, 8'h00, 1'b1, 1'b0, 1'b1, "sat_down_0");
        cycle(0, 0, 1, 0, 8'h00, 2'd1, 8'h00, 1'b1, 1'b1, 1'b1, "sat_down_pin");
        cycle(1, 0, 0, 0, 8'h00, 2'd1, 8'h00, 1'b1, 1'b0, 1'b0, "sat_clr");

        // Wrapping instance, range 0..9
        hard_reset();
        for (int i = 1; i <= 10; i++)
            cycle(0, 0, 1, 1, 8'h00, 2'd2, 8'(i % 10),
                  (i == 9), (i == 10), (i == 10), "mod_up");
        cycle(0, 0, 1, 1, 8'h00, 2'd2, 8'h01, 1'b0, 1'b0, 1'b1, "mod_up_1");
        cycle(0, 1, 0, 0, 8'h00, 2'd2, 8'h00, 1'b1, 1'b0, 1'b1, "mod_ld_0");
        cycle(0, 0, 1, 0, 8'h00, 2'd2, 8'h09, 1'b0, 1'b1, 1'b1, "mod_down_wrap");
        cycle(0, 0, 1, 0, 8'h00, 2'd2, 8'h08, 1'b0, 1'b0, 1'b1, "mod_down_8");

        // ---------------- final report ----------------
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
